// File: rtl/sdram_burst_ctrl.sv
// SDRAM burst controller: init sequence, ACT/RD/WR with auto-precharge, priority swap.
// Define SDRAM_AUTO_REFRESH_EN to include the periodic auto-refresh engine.
module sdram_burst_ctrl #(
  parameter int BURST_WORDS = 4,
  parameter int CAS_LAT     = 2,
  parameter int T_RCD       = 2,
  parameter int T_RP        = 2,
  parameter int T_WR        = 2,
  parameter int T_RC        = 7,
  parameter int T_INIT      = 10000,
  parameter int T_REF       = 780,
  localparam int ADDR_W     = 24,
  localparam int DATA_W     = 16 * BURST_WORDS
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iwrite_req,
  input  logic [ADDR_W-1:0] iwrite_address,
  input  logic [DATA_W-1:0] iwrite_data,
  output logic              owrite_ack,
  input  logic              iread_req,
  input  logic [ADDR_W-1:0] iread_address,
  output logic [DATA_W-1:0] oread_data,
  output logic              oread_ack,
  output logic              oinit_done,
  output logic [12:0]       DRAM_ADDR,
  output logic [1:0]        DRAM_BA,
  output logic              DRAM_CAS_N,
  output logic              DRAM_CKE,
  output logic              DRAM_CLK,
  output logic              DRAM_CS_N,
  output logic              DRAM_LDQM,
  output logic              DRAM_RAS_N,
  output logic              DRAM_UDQM,
  output logic              DRAM_WE_N,
  inout  wire  [15:0]       DRAM_DQ
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [2:0] BL = (BURST_WORDS == 8) ? 3'd3 :
                              (BURST_WORDS == 4) ? 3'd2 :
                              (BURST_WORDS == 2) ? 3'd1 : 3'd0;
  localparam logic [12:0] MRS_VAL = {6'b0, 3'(CAS_LAT), 1'b0, BL};

  localparam logic [15:0] INIT_END  = 16'(T_INIT - 1);
  localparam logic [15:0] RP_END    = 16'(T_RP - 1);
  localparam logic [15:0] RC_END    = 16'(T_RC - 1);
  localparam logic [15:0] RCD_END   = 16'(T_RCD - 1);
  localparam logic [15:0] WWAIT_END = 16'(T_WR + T_RP - 1);
  localparam logic [15:0] RD_END    = 16'(CAS_LAT + BURST_WORDS - 1);
  localparam logic [15:0] CL_C      = 16'(CAS_LAT);
  localparam logic [3:0]  BEAT_END  = 4'(BURST_WORDS - 1);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REF, S_ACT, S_WDATA, S_RDATA, S_WAIT, S_ACK
  } state_t;

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic [3:0]        beat_q;
  logic [3:0]        cmd_q;
  logic [12:0]       addr_q;
  logic [1:0]        ba_q;
  logic [15:0]       dq_q;
  logic              dq_oe_q;
  logic [8:0]        col_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;
  logic [DATA_W-1:0] rdata_q;
  logic              is_wr_q;
  logic              wack_q;
  logic              rack_q;
  logic              init_q;
  logic              prio_wr_q;

  logic              do_wr;
  logic              do_rd;
  logic              ref_go;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W+15:0] rsh;

  assign do_wr    = iwrite_req && (prio_wr_q || !iread_req);
  assign do_rd    = iread_req && !do_wr;
  assign sel_addr = do_wr ? iwrite_address : iread_address;
  assign wsh      = wdata_q >> 16;
  assign rsh      = {DRAM_DQ, rbuf_q};

`ifdef SDRAM_AUTO_REFRESH_EN
  localparam logic [15:0] REF_END = 16'(T_REF - 1);
  logic [15:0] rcnt_q;
  logic        rpend_q;

  assign ref_go = rpend_q;

  // pending clears in the same cycle IDLE turns it into a REF command
  always_ff @(posedge iclk) begin
    if (ireset) begin
      rcnt_q  <= '0;
      rpend_q <= 1'b0;
    end else if (init_q) begin
      if (state_q == S_IDLE && rpend_q) rpend_q <= 1'b0;
      if (rcnt_q == REF_END) begin
        rcnt_q  <= '0;
        rpend_q <= 1'b1;
      end else begin
        rcnt_q <= rcnt_q + 16'd1;
      end
    end
  end
`else
  assign ref_go = 1'b0;
`endif

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= S_INIT_WAIT;
      cnt_q     <= '0;
      beat_q    <= '0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      ba_q      <= '0;
      dq_q      <= '0;
      dq_oe_q   <= 1'b0;
      col_q     <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
      is_wr_q   <= 1'b0;
      wack_q    <= 1'b0;
      rack_q    <= 1'b0;
      init_q    <= 1'b0;
      prio_wr_q <= 1'b1;
    end else begin
      cmd_q  <= CMD_NOP;
      wack_q <= 1'b0;
      rack_q <= 1'b0;
      cnt_q  <= cnt_q + 16'd1;
      unique case (state_q)
        S_INIT_WAIT: if (cnt_q == INIT_END) begin
          cmd_q   <= CMD_PRE;
          addr_q  <= 13'h0400;
          ba_q    <= 2'd0;
          cnt_q   <= '0;
          state_q <= S_INIT_PRE;
        end
        S_INIT_PRE: if (cnt_q == RP_END) begin
          cmd_q   <= CMD_REF;
          cnt_q   <= '0;
          state_q <= S_INIT_REF1;
        end
        S_INIT_REF1: if (cnt_q == RC_END) begin
          cmd_q   <= CMD_REF;
          cnt_q   <= '0;
          state_q <= S_INIT_REF2;
        end
        S_INIT_REF2: if (cnt_q == RC_END) begin
          cmd_q   <= CMD_MRS;
          addr_q  <= MRS_VAL;
          ba_q    <= 2'd0;
          cnt_q   <= '0;
          state_q <= S_INIT_MRS;
        end
        S_INIT_MRS: if (cnt_q == RP_END) begin
          init_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          cnt_q <= '0;
          if (ref_go) begin
            cmd_q   <= CMD_REF;
            state_q <= S_REF;
          end else if (do_wr || do_rd) begin
            cmd_q   <= CMD_ACT;
            is_wr_q <= do_wr;
            ba_q    <= sel_addr[23:22];
            addr_q  <= sel_addr[21:9];
            col_q   <= sel_addr[8:0];
            wdata_q <= iwrite_data;
            state_q <= S_ACT;
          end
        end
        S_REF: if (cnt_q == RC_END) state_q <= S_IDLE;
        S_ACT: if (cnt_q == RCD_END) begin
          cmd_q  <= is_wr_q ? CMD_WR : CMD_RD;
          addr_q <= {3'b001, 1'b0, col_q};
          cnt_q  <= '0;
          beat_q <= '0;
          if (is_wr_q) begin
            dq_oe_q <= 1'b1;
            dq_q    <= wdata_q[15:0];
            state_q <= S_WDATA;
          end else begin
            state_q <= S_RDATA;
          end
        end
        S_WDATA: if (beat_q == BEAT_END) begin
          dq_oe_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end else begin
          beat_q  <= beat_q + 4'd1;
          wdata_q <= wsh;
          dq_q    <= wsh[15:0];
        end
        S_RDATA: begin
          // words shift in from the top so word 0 lands at the bottom
          if (cnt_q >= CL_C) rbuf_q <= rsh[DATA_W+15:16];
          if (cnt_q == RD_END) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: if (cnt_q == (is_wr_q ? WWAIT_END : RP_END)) begin
          state_q <= S_ACK;
          if (is_wr_q) begin
            wack_q    <= 1'b1;
            prio_wr_q <= 1'b0;
          end else begin
            rack_q    <= 1'b1;
            rdata_q   <= rbuf_q;
            prio_wr_q <= 1'b1;
          end
        end
        S_ACK: state_q <= S_IDLE;
        default: state_q <= S_INIT_WAIT;
      endcase
    end
  end

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
  assign DRAM_ADDR  = addr_q;
  assign DRAM_BA    = ba_q;
  assign DRAM_DQ    = dq_oe_q ? dq_q : 16'hzzzz;
  assign DRAM_CLK   = ~iclk;
  assign DRAM_CKE   = 1'b1;
  assign DRAM_LDQM  = 1'b0;
  assign DRAM_UDQM  = 1'b0;
  assign owrite_ack = wack_q;
  assign oread_ack  = rack_q;
  assign oread_data = rdata_q;
  assign oinit_done = init_q;

endmodule

// File: tb/tb_sdram_burst_ctrl.sv
// Scoreboard bench for sdram_burst_ctrl: command, DQ and ack queues checked by a monitor.
// Refresh expectations follow SDRAM_AUTO_REFRESH_EN.
module tb_sdram_burst_ctrl;
  localparam int BW = 4, CL = 2, TINIT = 20, TREF = 100;
  localparam int TRCD = 2, TRP = 2, TWR = 2, TRC = 7;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101;
  localparam logic [3:0] C_WR = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic wreq = 0, rreq = 0;
  logic [23:0] waddr = 0, raddr = 0;
  logic [63:0] wdata = 0;
  wire wack, rack, init_done;
  wire [63:0] rdata;
  wire [12:0] da;
  wire [1:0] dba;
  wire cas_n, cke, dclk, cs_n, ldqm, ras_n, udqm, we_n;
  wire [15:0] dq;
  logic [15:0] dq_drv = 0;
  logic dq_en = 0;
  assign dq = dq_en ? dq_drv : 16'hzzzz;

  sdram_burst_ctrl #(
    .BURST_WORDS(BW), .CAS_LAT(CL), .T_RCD(TRCD), .T_RP(TRP),
    .T_WR(TWR), .T_RC(TRC), .T_INIT(TINIT), .T_REF(TREF)
  ) dut (
    .iclk(clk), .ireset(rst),
    .iwrite_req(wreq), .iwrite_address(waddr), .iwrite_data(wdata),
    .owrite_ack(wack),
    .iread_req(rreq), .iread_address(raddr), .oread_data(rdata),
    .oread_ack(rack), .oinit_done(init_done),
    .DRAM_ADDR(da), .DRAM_BA(dba), .DRAM_CAS_N(cas_n), .DRAM_CKE(cke),
    .DRAM_CLK(dclk), .DRAM_CS_N(cs_n), .DRAM_LDQM(ldqm),
    .DRAM_RAS_N(ras_n), .DRAM_UDQM(udqm), .DRAM_WE_N(we_n), .DRAM_DQ(dq)
  );

  typedef struct {
    logic [3:0] cmd; logic chk_a; logic [1:0] ba; logic [12:0] a;
    int gap; string name;
  } cmd_e;
  typedef struct { logic is_wr; logic [63:0] data; int gap; } ack_e;

  cmd_e exp_cmd[$];
  ack_e exp_ack[$];
  logic [15:0] exp_dq[$];
  int exp_dq_k[$];

  int checks = 0, errors = 0, cyc = 0;
  int last_cmd_cyc = 0, last_rw_cyc = 0, last_ref_cyc = 0;
  int wr_cyc = 0, rd_cyc = 0, post_refs = 0;
  logic in_access = 0, prev_ack = 0, prev_rack = 0, prev_init = 0;
  logic wr_act = 0, rd_act = 0;
  logic [63:0] held_rdata = 0;
  logic [23:0] wr_base = 0, rd_base = 0;
  logic [12:0] open_row [4];
  logic [15:0] mem [logic [23:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  task automatic push_cmd(logic [3:0] c, logic ca, logic [1:0] b,
                          logic [12:0] a, int gap, string nm);
    cmd_e e;
    e.cmd = c; e.chk_a = ca; e.ba = b; e.a = a; e.gap = gap; e.name = nm;
    exp_cmd.push_back(e);
  endtask

  task automatic push_init();
    push_cmd(C_PRE, 1, 2'd0, 13'h0400, TINIT, "init_pre");
    push_cmd(C_REF, 0, 2'd0, 13'h0, TRP, "init_ref1");
    push_cmd(C_REF, 0, 2'd0, 13'h0, TRC, "init_ref2");
    push_cmd(C_MRS, 1, 2'd0, 13'h0022, TRC, "init_mrs");
  endtask

  task automatic push_access(logic is_wr, logic [23:0] ad, logic [63:0] d,
                             logic with_ack, int nwords);
    ack_e a;
    push_cmd(C_ACT, 1, ad[23:22], ad[21:9], 0, "act");
    push_cmd(is_wr ? C_WR : C_RD, 1, ad[23:22], {4'b0010, ad[8:0]}, TRCD,
             is_wr ? "wr" : "rd");
    if (is_wr)
      for (int k = 0; k < nwords; k++) begin
        exp_dq.push_back(d[16*k +: 16]);
        exp_dq_k.push_back(k);
      end
    if (with_ack) begin
      a.is_wr = is_wr; a.data = d;
      a.gap = is_wr ? (BW + TWR + TRP) : (CL + BW + TRP);
      exp_ack.push_back(a);
    end
  endtask

  // memory model: drives read bursts CAS_LAT cycles after RD
  always @(posedge clk) begin
    logic [23:0] key;
    #1;
    if (rd_act && cyc >= rd_cyc + CL && cyc < rd_cyc + CL + BW) begin
      key = rd_base + 24'(cyc - rd_cyc - CL);
      dq_drv = mem.exists(key) ? mem[key] : 16'h0;
      dq_en = 1;
    end else begin
      dq_en = 0;
    end
  end

  always @(negedge clk) begin : mon
    logic [3:0] c;
    cmd_e e;
    ack_e a;
    c = {cs_n, ras_n, cas_n, we_n};
    if (rst) begin
      in_access = 0; wr_act = 0; rd_act = 0;
    end
    if (init_done && !prev_init) last_ref_cyc = cyc;
    prev_init = init_done;
    if (c != C_NOP) begin
      if (c == C_REF && init_done) begin
`ifdef SDRAM_AUTO_REFRESH_EN
        chk("ref_in_access", in_access, 0);
        chk("ref_interval_ok", (cyc - last_ref_cyc) <= TREF + 16, 1);
`else
        chk("no_auto_ref", post_refs, 0);
`endif
        post_refs++;
        last_ref_cyc = cyc;
      end else if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmd got=%b want=none cyc=%0d", c, cyc);
      end else begin
        e = exp_cmd.pop_front();
        chk({e.name, "_cmd"}, c, e.cmd);
        if (e.chk_a) chk({e.name, "_addr"}, {dba, da}, {e.ba, e.a});
        if (e.gap > 0) chk({e.name, "_gap"}, cyc - last_cmd_cyc, e.gap);
        last_cmd_cyc = cyc;
      end
      if (c == C_ACT) begin open_row[dba] = da; in_access = 1; end
      if (c == C_WR) begin
        wr_act = 1; wr_cyc = cyc; last_rw_cyc = cyc;
        wr_base = {dba, open_row[dba], da[8:0]};
      end
      if (c == C_RD) begin
        rd_act = 1; rd_cyc = cyc; last_rw_cyc = cyc;
        rd_base = {dba, open_row[dba], da[8:0]};
      end
    end
    if (!dq_en && dq !== 16'hzzzz) begin
      if (exp_dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dq_driven got=%h want=z cyc=%0d", dq, cyc);
      end else begin
        chk("dq_word", dq, exp_dq.pop_front());
        chk("dq_slot", cyc - wr_cyc, exp_dq_k.pop_front());
      end
      if (wr_act) mem[wr_base + 24'(cyc - wr_cyc)] = dq;
    end
    if (prev_rack && !rack) chk("rd_hold", rdata, held_rdata);
    if (wack || rack) begin
      chk("ack_single_cycle", prev_ack, 0);
      if (exp_ack.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack got=w%b_r%b want=none cyc=%0d",
                 wack, rack, cyc);
      end else begin
        a = exp_ack.pop_front();
        chk("ack_kind", {wack, rack}, {a.is_wr, !a.is_wr});
        if (!a.is_wr) chk("rd_data", rdata, a.data);
        chk("ack_lat", cyc - last_rw_cyc, a.gap);
      end
      in_access = 0;
    end
    prev_ack = wack | rack;
    prev_rack = rack;
    held_rdata = rdata;
  end

  task automatic release_reset();
    @(negedge clk);
    push_init();
    rst = 0;
    last_cmd_cyc = cyc;
  endtask

  task automatic wait_init();
    int t = 0;
    while (!init_done && t < TINIT + 100) begin @(negedge clk); t++; end
    chk("init_done", init_done, 1);
    chk("init_done_lat", cyc - last_cmd_cyc, TRP);
  endtask

  task automatic wait_acks(int n);
    int got = 0, t = 0;
    while (got < n && t < 100 * n) begin
      @(negedge clk); t++;
      if (wack || rack) got++;
    end
    chk("ack_count", got, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", {cs_n, ras_n, cas_n, we_n}, C_NOP);
    chk("rst_addr", da, 0);
    chk("rst_ba", dba, 0);
    chk("rst_dq_z", dq === 16'hzzzz, 1);
    chk("rst_wack", wack, 0);
    chk("rst_rack", rack, 0);
    chk("rst_init", init_done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cke_dqm", {cke, ldqm, udqm}, 3'b100);
    release_reset();
    wait_init();

    push_access(1, 24'h012345, 64'h4444_3333_2222_1111, 1, BW);
    waddr = 24'h012345; wdata = 64'h4444_3333_2222_1111; wreq = 1;
    wait_acks(1); wreq = 0;

    push_access(0, 24'h012345, 64'h4444_3333_2222_1111, 1, 0);
    raddr = 24'h012345; rreq = 1;
    wait_acks(1); rreq = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      push_access(1, 24'hC00010, 64'hDDDD_CCCC_BBBB_AAAA, 1, BW);
      push_access(0, 24'h012345, 64'h4444_3333_2222_1111, 1, 0);
    end
    waddr = 24'hC00010; wdata = 64'hDDDD_CCCC_BBBB_AAAA;
    raddr = 24'h012345; wreq = 1; rreq = 1;
    wait_acks(4); wreq = 0; rreq = 0;

    for (int i = 0; i < 6; i++)
      push_access(0, 24'hC00010, 64'hDDDD_CCCC_BBBB_AAAA, 1, 0);
    raddr = 24'hC00010; rreq = 1;
    wait_acks(6); rreq = 0;
    repeat (4) @(negedge clk);

    push_access(1, 24'h012345, 64'h8888_7777_6666_5555, 0, 3);
    waddr = 24'h012345; wdata = 64'h8888_7777_6666_5555; wreq = 1;
    t = 0;
    while (dq !== 16'h7777 && t < 200) begin @(negedge clk); t++; end
    chk("reached_word2", dq, 16'h7777);
    rst = 1; wreq = 0;
    @(negedge clk);
    chk("midrst_cmd", {cs_n, ras_n, cas_n, we_n}, C_NOP);
    chk("midrst_dq_z", dq === 16'hzzzz, 1);
    chk("midrst_init", init_done, 0);
    chk("midrst_wack", wack, 0);
    chk("midrst_cmd_q", exp_cmd.size(), 0);
    repeat (2) @(negedge clk);
    release_reset();
    wait_init();
    repeat (150) @(negedge clk);

    chk("end_cmd_q", exp_cmd.size(), 0);
    chk("end_dq_q", exp_dq.size(), 0);
    chk("end_ack_q", exp_ack.size(), 0);
`ifdef SDRAM_AUTO_REFRESH_EN
    chk("refresh_seen", post_refs > 0, 1);
`else
    chk("refresh_absent", post_refs, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_burst_ctrl.md
SDRAM_BURST_CTRL -- requirements
Module: sdram_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 4: 16-bit words per access; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter CAS_LAT, default 2: CAS latency in cycles; legal values 2, 3.
REQ-003 SHALL have parameters T_RCD=2, T_RP=2, T_WR=2, T_RC=7: SDRAM timings in iclk cycles, each at least 1.
REQ-004 SHALL have parameters T_INIT=10000 (power-up wait in cycles) and T_REF=780 (refresh interval in cycles).
REQ-005 SHALL define ADDR_W=24 as {bank[1:0], row[12:0], column[8:0]} and DATA_W=16*BURST_WORDS.
REQ-006 SHALL have port iclk, input, 1 bit: the single clock.
REQ-007 SHALL have port ireset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports iwrite_req in 1, iwrite_address in ADDR_W, iwrite_data in DATA_W, owrite_ack out 1.
REQ-009 SHALL have ports iread_req in 1, iread_address in ADDR_W, oread_data out DATA_W, oread_ack out 1.
REQ-010 SHALL have port oinit_done, output, 1 bit: high from the end of initialisation until reset.
REQ-011 SHALL have SDRAM ports DRAM_ADDR out 13, DRAM_BA out 2, DRAM_CAS_N/CKE/CLK/CS_N/LDQM/RAS_N/UDQM/WE_N out 1, DRAM_DQ inout 16.

Function
REQ-012 SHALL encode commands as {CS_N,RAS_N,CAS_N,WE_N}: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000.
REQ-013 SHALL register all command, address and DQ outputs; DRAM_CLK SHALL be ~iclk; CKE SHALL be 1; LDQM/UDQM SHALL be 0.
REQ-014 SHALL step init states INIT_WAIT (T_INIT cycles of NOP), PRE all banks (A10=1), REF, REF, MRS, then IDLE, with T_RP/T_RC NOP gaps.
REQ-015 SHALL program MRS with A[2:0]=log2(BURST_WORDS), A3=0, A[6:4]=CAS_LAT, other bits 0.
REQ-016 SHALL raise oinit_done in the first IDLE cycle.
REQ-017 SHALL arbitrate from IDLE in this order: pending refresh, then whichever of read/write has priority, then the other.
REQ-018 SHALL give read priority after a completed write and write priority after a completed read; write SHALL have priority after reset.
REQ-019 SHALL sample address and write data at ACT; requests SHALL be level-sensitive and held by the requester until the ack.
REQ-020 SHALL perform an access as: ACT; T_RCD-1 NOPs; RD/WR with A10=1 (auto-precharge) and column on A[8:0].
REQ-021 SHALL on write drive DQ with word k (iwrite_data[16k+15:16k]) in WR cycle + k, for k=0..BURST_WORDS-1.
REQ-022 SHALL on write release DQ, wait T_WR+T_RP cycles, then pulse owrite_ack high for exactly 1 cycle.
REQ-023 SHALL on read capture DQ into word k at RD cycle + CAS_LAT + k, then wait T_RP cycles and pulse oread_ack for 1 cycle.
REQ-024 SHALL keep oread_data valid with oread_ack and hold it until the next read completes.
REQ-025 SHALL tri-state DQ in every cycle outside write data cycles.
REQ-026 SHALL run a refresh counter from oinit_done; on reaching T_REF-1 it SHALL set refresh_pending and restart from 0.
REQ-027 SHALL service refresh as REF plus T_RC-1 NOPs, clearing refresh_pending at REF.
REQ-028 SHALL start refresh only from IDLE, never aborting an access; a refresh that fell due during an access SHALL run before the next access.
REQ-029 SHALL, when iread_req and iwrite_req are both high in IDLE, serve the priority side and the other on the next IDLE visit.

Reset
REQ-030 SHALL, on ireset at any cycle (including mid-burst), enter INIT_WAIT on the next edge and restart initialisation.
REQ-031 SHALL reset to: command NOP, DRAM_ADDR=0, DRAM_BA=0, DQ tri-stated, owrite_ack=0, oread_ack=0, oinit_done=0, oread_data=0, refresh counter=0, refresh_pending=0, priority=write.

Configuration
REQ-032 SHALL, with macro SDRAM_AUTO_REFRESH_EN defined, include the refresh counter and REQ-026..028.
REQ-033 SHALL, with SDRAM_AUTO_REFRESH_EN undefined, omit the counter so IDLE never enters refresh; the init REF commands SHALL remain.

Verification
REQ-034 SHALL be checked with T_INIT=20, BURST_WORDS=4, CAS_LAT=2: after reset release -> PRE, REF, REF, MRS with A=0x022; oinit_done=1 after the init sequence completes.
REQ-035 SHALL be checked by a write of address 0x012345, data 0x4444_3333_2222_1111 -> BA=0, ACT row 0x091, WR col 0x145 A10=1, DQ 1111,2222,3333,4444; 1-cycle owrite_ack.
REQ-036 SHALL be checked by a read of the same address against a memory model -> oread_data=0x4444_3333_2222_1111 with a 1-cycle oread_ack.
REQ-037 SHALL be checked with both requests held continuously -> order write, read, write, read.
REQ-038 SHALL be checked with T_REF=100 and back-to-back requests -> REF every <=100+access-length cycles, never inside an ACT..ack window.
REQ-039 SHALL be checked with ireset asserted during write data word 2 -> NOP, DQ tri-stated, oinit_done=0 the next cycle, no owrite_ack.
